dec_scan_sequencer: RTL and testbench

//   Upstream driver for the 4-to-16 decoder: generates the 4-bit row code W and enable EN

---
 rtl/dec_scan_sequencer_if.sv | 22 ++
 rtl/dec_scan_sequencer.sv | 155 +++++++++++++++
 tb/tb_dec_scan_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dec_scan_sequencer_if.sv
// Row-scan bus between a controller and the decoder driver: scan control in,
// decoder code/enable and scan status out.
interface dec_scan_sequencer_if;
  logic        start;
  logic        stop;
  logic        mode;
  logic [15:0] row_mask;
  logic [3:0]  W;
  logic        EN;
  logic        busy;
  logic        frame_done;

  modport master (
    output start, stop, mode, row_mask,
    input  W, EN, busy, frame_done
  );

  modport slave (
    input  start, stop, mode, row_mask,
    output W, EN, busy, frame_done
  );
endinterface

// File: rtl/dec_scan_sequencer.sv
// Drives the 4-to-16 decoder: each enabled row gets DWELL cycles of EN high,
// separated by BLANK cycles of EN low, in single-pass or continuous mode.
module dec_scan_sequencer #(
  parameter int DWELL = 4,
  parameter int BLANK = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dec_scan_sequencer_if.slave  bus
);

  localparam int MAXC = (DWELL > BLANK) ? ((DWELL > 2) ? DWELL : 2)
                                        : ((BLANK > 2) ? BLANK : 2);
  localparam int CW = $clog2(MAXC);
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LD = CW'((BLANK > 0) ? BLANK - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_BLANK} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [3:0]     w_reg, w_next;
  logic [3:0]     pend_reg, pend_next;
  logic           en_reg, en_next;
  logic           busy_reg, busy_next;
  logic           fd_reg, fd_next;
  logic [15:0]    mask_reg, mask_next;
  logic           mode_reg, mode_next;
  logic [15:0]    above;

  function automatic logic [3:0] lowest_idx(input logic [15:0] m);
    lowest_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) lowest_idx = 4'(i);
    end
  endfunction

  // Enabled rows strictly after the row currently on the decoder
  genvar gi;
  for (gi = 0; gi < 16; gi++) begin : g_above
    assign above[gi] = mask_reg[gi] && (4'(gi) > w_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      w_reg     <= '0;
      pend_reg  <= '0;
      en_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      fd_reg    <= 1'b0;
      mask_reg  <= '0;
      mode_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      w_reg     <= w_next;
      pend_reg  <= pend_next;
      en_reg    <= en_next;
      busy_reg  <= busy_next;
      fd_reg    <= fd_next;
      mask_reg  <= mask_next;
      mode_reg  <= mode_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    w_next     = w_reg;
    pend_next  = pend_reg;
    en_next    = en_reg;
    busy_next  = busy_reg;
    fd_next    = 1'b0;
    mask_next  = mask_reg;
    mode_next  = mode_reg;
    case (state_reg)
      S_IDLE: begin
        en_next   = 1'b0;
        busy_next = 1'b0;
        if (bus.start && !bus.stop && bus.row_mask != '0) begin
          mask_next  = bus.row_mask;
          mode_next  = bus.mode;
          w_next     = lowest_idx(bus.row_mask);
          en_next    = 1'b1;
          busy_next  = 1'b1;
          cnt_next   = DWELL_LD;
          state_next = S_ON;
        end
      end
      S_ON: begin
        if (bus.stop) begin
          state_next = S_IDLE;
          en_next    = 1'b0;
          busy_next  = 1'b0;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (above != '0) begin
          if (BLANK > 0) begin
            state_next = S_BLANK;
            en_next    = 1'b0;
            cnt_next   = BLANK_LD;
            pend_next  = lowest_idx(above);
          end else begin
            w_next   = lowest_idx(above);
            cnt_next = DWELL_LD;
          end
        end else begin
          // Frame end: continuous mode picks up the live mask for the next frame
          fd_next = 1'b1;
          if (!mode_reg) mask_next = bus.row_mask;
          if (mode_reg || bus.row_mask == '0) begin
            state_next = S_IDLE;
            en_next    = 1'b0;
            busy_next  = 1'b0;
          end else if (BLANK > 0) begin
            state_next = S_BLANK;
            en_next    = 1'b0;
            cnt_next   = BLANK_LD;
            pend_next  = lowest_idx(bus.row_mask);
          end else begin
            w_next   = lowest_idx(bus.row_mask);
            cnt_next = DWELL_LD;
          end
        end
      end
      S_BLANK: begin
        if (bus.stop) begin
          state_next = S_IDLE;
          en_next    = 1'b0;
          busy_next  = 1'b0;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          w_next     = pend_reg;
          en_next    = 1'b1;
          cnt_next   = DWELL_LD;
          state_next = S_ON;
        end
      end
      default: begin
        state_next = S_IDLE;
        en_next    = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign bus.W          = w_reg;
  assign bus.EN         = en_reg;
  assign bus.busy       = busy_reg;
  assign bus.frame_done = fd_reg;

endmodule

// File: tb/tb_dec_scan_sequencer.sv
// Randomized bench for dec_scan_sequencer: a schedule model expands each frame
// into per-cycle expectations (dwell, blank, idle) compared on the falling edge.
module tb_dec_scan_sequencer;
  localparam int DWELL   = 4;
  localparam int BLANK_A = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, mode, sel;
  logic [15:0] row_mask;
  int          checks = 0;
  int          errors = 0;

  dec_scan_sequencer_if a_if ();
  dec_scan_sequencer_if b_if ();

  assign a_if.start    = start;
  assign a_if.stop     = stop;
  assign a_if.mode     = mode;
  assign a_if.row_mask = row_mask;
  assign b_if.start    = start;
  assign b_if.stop     = stop;
  assign b_if.mode     = mode;
  assign b_if.row_mask = row_mask;

  dec_scan_sequencer #(.DWELL(DWELL), .BLANK(BLANK_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  dec_scan_sequencer #(.DWELL(DWELL), .BLANK(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  always #5 clk = ~clk;

  logic [3:0] obs_w;
  logic       obs_en, obs_busy, obs_fd;
  assign obs_w    = sel ? b_if.W          : a_if.W;
  assign obs_en   = sel ? b_if.EN         : a_if.EN;
  assign obs_busy = sel ? b_if.busy       : a_if.busy;
  assign obs_fd   = sel ? b_if.frame_done : a_if.frame_done;

  // Schedule model: one entry per expected cycle
  typedef struct packed {
    logic [3:0] w;
    logic       en;
    logic       busy;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   last_w;
  bit   fd_pend;

  function automatic void model_begin();
    exp_q.delete();
    fd_pend = 1'b0;
  endfunction

  function automatic void push(input int w, input bit en, input bit busy);
    exp_t e;
    e.w = 4'(w); e.en = en; e.busy = busy; e.fd = fd_pend;
    fd_pend = 1'b0;
    exp_q.push_back(e);
  endfunction

  function automatic void model_frame(input logic [15:0] m, input int blank, input bit first);
    bit lead = !first;
    for (int k = 0; k < 16; k++) begin
      if (m[k]) begin
        if (lead) for (int i = 0; i < blank; i++) push(last_w, 1'b0, 1'b1);
        for (int i = 0; i < DWELL; i++) push(k, 1'b1, 1'b1);
        last_w = k;
        lead   = 1'b1;
      end
    end
    fd_pend = 1'b1;
  endfunction

  function automatic void model_idle(input int n);
    for (int i = 0; i < n; i++) push(last_w, 1'b0, 1'b0);
  endfunction

  task automatic quiesce();
    @(negedge clk);
    start = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; mode = 1'b0; row_mask = '0; sel = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_if.W, a_if.EN, a_if.busy, a_if.frame_done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_a: got W=%0d EN=%b busy=%b fd=%b, need all 0",
               a_if.W, a_if.EN, a_if.busy, a_if.frame_done);
    end
    checks++;
    if ({b_if.W, b_if.EN, b_if.busy, b_if.frame_done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_b: got W=%0d EN=%b busy=%b fd=%b, need all 0",
               b_if.W, b_if.EN, b_if.busy, b_if.frame_done);
    end
    rst_n = 1'b1;
    last_w = 0;
  endtask

  task automatic test_single_pass();
    exp_t e;
    logic [15:0] m;
    int ign, busy_len;
    sel = 1'b0;
    for (int it = 0; it < 4; it++) begin
      m = (it == 0) ? 16'hFFFF : 16'($urandom_range(1, 65535));
      model_begin();
      model_frame(m, BLANK_A, 1'b1);
      busy_len = exp_q.size();
      model_idle(3);
      ign = $urandom_range(1, busy_len);
      @(negedge clk);
      start = 1'b1; mode = 1'b1; row_mask = m;
      for (int cyc = 1; exp_q.size() > 0; cyc++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({obs_w, obs_en, obs_busy, obs_fd} !== e) begin
          errors++;
          $display("FAIL single_pass mask=%h cyc %0d: got W=%0d EN=%b busy=%b fd=%b, need W=%0d EN=%b busy=%b fd=%b",
                   m, cyc, obs_w, obs_en, obs_busy, obs_fd, e.w, e.en, e.busy, e.fd);
        end
        start = (cyc == ign);
        if (cyc <= busy_len) begin
          row_mask = 16'($urandom);
          mode     = 1'($urandom);
        end
      end
      $display("single_pass mask=%h done", m);
      start = 1'b0;
      quiesce();
    end
  endtask

  task automatic test_continuous();
    exp_t e;
    logic [15:0] m1, m2;
    sel = 1'b0;
    for (int it = 0; it < 3; it++) begin
      m1 = (it == 0) ? 16'h8421 : 16'($urandom_range(1, 65535));
      m2 = (it == 0) ? 16'h8421 : (it == 1) ? 16'($urandom_range(1, 65535)) : 16'h0000;
      model_begin();
      model_frame(m1, BLANK_A, 1'b1);
      if (m2 != 0) begin
        model_frame(m2, BLANK_A, 1'b0);
        model_frame(m2, BLANK_A, 1'b0);
      end else begin
        model_idle(3);
      end
      @(negedge clk);
      start = 1'b1; mode = 1'b0; row_mask = m1;
      for (int cyc = 1; exp_q.size() > 0; cyc++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({obs_w, obs_en, obs_busy, obs_fd} !== e) begin
          errors++;
          $display("FAIL continuous m1=%h m2=%h cyc %0d: got W=%0d EN=%b busy=%b fd=%b, need W=%0d EN=%b busy=%b fd=%b",
                   m1, m2, cyc, obs_w, obs_en, obs_busy, obs_fd, e.w, e.en, e.busy, e.fd);
        end
        start = 1'b0;
        if (cyc == 2) row_mask = m2;
      end
      if (m2 != 0) begin
        // stop lands on the frame-end edge: no frame_done may follow
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if ({obs_w, obs_en, obs_busy, obs_fd} !== {4'(last_w), 3'b000}) begin
          errors++;
          $display("FAIL continuous_stop: got W=%0d EN=%b busy=%b fd=%b, need W=%0d EN=0 busy=0 fd=0",
                   obs_w, obs_en, obs_busy, obs_fd, last_w);
        end
      end
      $display("continuous m1=%h m2=%h done", m1, m2);
      quiesce();
    end
  endtask

  task automatic test_ignored();
    logic [3:0] w_hold;
    sel = 1'b0;
    w_hold = 4'(last_w);
    @(negedge clk);
    start = 1'b1; mode = 1'b1; row_mask = 16'h0000;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({obs_w, obs_en, obs_busy, obs_fd} !== {w_hold, 3'b000}) begin
        errors++;
        $display("FAIL zero_mask cyc %0d: got W=%0d EN=%b busy=%b fd=%b, need W=%0d EN=0 busy=0 fd=0",
                 cyc, obs_w, obs_en, obs_busy, obs_fd, w_hold);
      end
    end
    @(negedge clk);
    start = 1'b1; stop = 1'b1; row_mask = 16'hFFFF;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      checks++;
      if ({obs_w, obs_en, obs_busy, obs_fd} !== {w_hold, 3'b000}) begin
        errors++;
        $display("FAIL start_stop cyc %0d: got W=%0d EN=%b busy=%b fd=%b, need W=%0d EN=0 busy=0 fd=0",
                 cyc, obs_w, obs_en, obs_busy, obs_fd, w_hold);
      end
    end
    $display("ignored starts done");
  endtask

  task automatic test_stop_restart();
    exp_t e;
    sel = 1'b0;
    model_begin();
    model_frame(16'hFFFF, BLANK_A, 1'b1);
    @(negedge clk);
    start = 1'b1; mode = 1'b1; row_mask = 16'hFFFF;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({obs_w, obs_en, obs_busy, obs_fd} !== e) begin
        errors++;
        $display("FAIL stop_pre cyc %0d: got W=%0d EN=%b busy=%b fd=%b, need W=%0d EN=%b busy=%b fd=%b",
                 cyc, obs_w, obs_en, obs_busy, obs_fd, e.w, e.en, e.busy, e.fd);
      end
      start = 1'b0;
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if ({obs_w, obs_en, obs_busy, obs_fd} !== {e.w, 3'b000}) begin
      errors++;
      $display("FAIL stop_row3: got W=%0d EN=%b busy=%b fd=%b, need W=%0d EN=0 busy=0 fd=0",
               obs_w, obs_en, obs_busy, obs_fd, e.w);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({obs_w, obs_en, obs_busy, obs_fd} !== {4'd0, 3'b110}) begin
      errors++;
      $display("FAIL restart: got W=%0d EN=%b busy=%b fd=%b, need W=0 EN=1 busy=1 fd=0",
               obs_w, obs_en, obs_busy, obs_fd);
    end
    $display("stop/restart done");
    quiesce();
  endtask

  task automatic test_async_reset();
    exp_t e;
    sel = 1'b0;
    model_begin();
    model_frame(16'hFFFF, BLANK_A, 1'b1);
    @(negedge clk);
    start = 1'b1; mode = 1'b1; row_mask = 16'hFFFF;
    for (int cyc = 1; cyc <= 44; cyc++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({obs_w, obs_en, obs_busy, obs_fd} !== e) begin
        errors++;
        $display("FAIL areset_pre cyc %0d: got W=%0d EN=%b busy=%b fd=%b, need W=%0d EN=%b busy=%b fd=%b",
                 cyc, obs_w, obs_en, obs_busy, obs_fd, e.w, e.en, e.busy, e.fd);
      end
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_if.W, a_if.EN, a_if.busy, a_if.frame_done} !== 7'b0) begin
      errors++;
      $display("FAIL areset_a: got W=%0d EN=%b busy=%b fd=%b, need all 0",
               a_if.W, a_if.EN, a_if.busy, a_if.frame_done);
    end
    checks++;
    if ({b_if.W, b_if.EN, b_if.busy, b_if.frame_done} !== 7'b0) begin
      errors++;
      $display("FAIL areset_b: got W=%0d EN=%b busy=%b fd=%b, need all 0",
               b_if.W, b_if.EN, b_if.busy, b_if.frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_w = 0;
    $display("async reset done");
  endtask

  task automatic test_no_blank();
    exp_t e;
    logic [15:0] m;
    sel = 1'b1;
    for (int it = 0; it < 2; it++) begin
      m = (it == 0) ? 16'h000F : 16'($urandom_range(1, 65535));
      model_begin();
      model_frame(m, 0, 1'b1);
      if (it == 0) model_idle(3);
      else begin
        model_frame(m, 0, 1'b0);
        model_frame(m, 0, 1'b0);
      end
      @(negedge clk);
      start = 1'b1; mode = (it == 0); row_mask = m;
      for (int cyc = 1; exp_q.size() > 0; cyc++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({obs_w, obs_en, obs_busy, obs_fd} !== e) begin
          errors++;
          $display("FAIL no_blank mask=%h cyc %0d: got W=%0d EN=%b busy=%b fd=%b, need W=%0d EN=%b busy=%b fd=%b",
                   m, cyc, obs_w, obs_en, obs_busy, obs_fd, e.w, e.en, e.busy, e.fd);
        end
        start = 1'b0;
      end
      $display("no_blank mask=%h mode=%0d done", m, (it == 0));
      quiesce();
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_continuous();
    test_ignored();
    test_stop_restart();
    test_async_reset();
    test_no_blank();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
